flash_rom_loader: RTL and testbench

FLASH_ROM_LOADER -- requirements
Module: flash_rom_loader

---
 rtl/flash_rom_loader.sv | 173 +++++++++++++++++
 tb/tb_flash_rom_loader.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_rom_loader.sv
// Copies a byte block from a serial flash reader into RAM, one read strobe per byte.
// Optional running 16-bit byte checksum enabled by defining FLASH_LOADER_CSUM_EN.
module flash_rom_loader #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [23:0]       src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              loading,
    output logic              done,
    output logic [15:0]       csum,
    output logic              fl_rst_n,
    output logic [23:0]       fl_addr,
    output logic              fl_rd,
    output logic              fl_terminate,
    input  logic [7:0]        fl_dout,
    input  logic              fl_data_ready,
    input  logic              fl_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic              ram_wait
);

    // state     | meaning
    // IDLE      | waiting for start, parameters latched on accept
    // WAIT_RDY  | waiting for the reader to go idle (absorbs power-up)
    // ISSUE     | one-cycle read strobe
    // WAIT_ACK  | waiting for the reader to report busy
    // WAIT_DATA | waiting for a valid byte with the reader idle again
    // WRITE     | RAM write held until ram_wait is low
    // NEXT      | advance RAM address, count down remaining bytes
    // TERM      | end-of-burst request until the reader acknowledges
    // REARM     | one-cycle reader reset to leave its terminal state
    // FINISH    | one-cycle done pulse
    typedef enum logic [3:0] {
        IDLE,
        WAIT_RDY,
        ISSUE,
        WAIT_ACK,
        WAIT_DATA,
        WRITE,
        NEXT,
        TERM,
        REARM,
        FINISH
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [LEN_W-1:0] remaining;

    // Outputs are registered and set on the transition into the state that owns them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            loading      <= 1'b0;
            done         <= 1'b0;
            fl_rd        <= 1'b0;
            fl_terminate <= 1'b0;
            fl_rst_n     <= 1'b0;
            fl_addr      <= '0;
            ram_addr     <= '0;
            ram_din      <= '0;
            ram_we       <= 1'b0;
            remaining    <= '0;
        end else begin
            done     <= 1'b0;
            fl_rd    <= 1'b0;
            fl_rst_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        fl_addr   <= src_addr;
                        ram_addr  <= dst_addr;
                        remaining <= length;
                        loading   <= 1'b1;
                        if (length == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (!fl_busy) begin
                        state <= ISSUE;
                        fl_rd <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (fl_busy) begin
                        state <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (fl_data_ready && !fl_busy) begin
                        ram_din <= fl_dout;
                        ram_we  <= 1'b1;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (!ram_wait) begin
                        ram_we <= 1'b0;
                        state  <= NEXT;
                    end
                end
                NEXT: begin
                    ram_addr  <= ram_addr + ADDR_ONE;
                    remaining <= remaining - LEN_ONE;
                    if (remaining == LEN_ONE) begin
                        state        <= TERM;
                        fl_terminate <= 1'b1;
                    end else begin
                        state <= ISSUE;
                        fl_rd <= 1'b1;
                    end
                end
                TERM: begin
                    if (fl_busy) begin
                        fl_terminate <= 1'b0;
                        fl_rst_n     <= 1'b0;
                        state        <= REARM;
                    end
                end
                REARM: begin
                    done  <= 1'b1;
                    state <= FINISH;
                end
                FINISH: begin
                    loading <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    loading      <= 1'b0;
                    ram_we       <= 1'b0;
                    fl_terminate <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifdef FLASH_LOADER_CSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else if (state == IDLE && start) begin
            csum_q <= '0;
        end else if (state == WRITE && !ram_wait) begin
            csum_q <= csum_q + {8'h00, ram_din};
        end
    end

    assign csum = csum_q;
`else
    assign csum = 16'h0000;
`endif

endmodule

// File: tb/tb_flash_rom_loader.sv
// Directed bench for flash_rom_loader with a behavioural flash reader and stallable RAM.
module tb_flash_rom_loader;

`ifdef FLASH_LOADER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] length;
    logic        loading;
    logic        done;
    logic [15:0] csum;
    logic        fl_rst_n;
    logic [23:0] fl_addr;
    logic        fl_rd;
    logic        fl_terminate;
    logic [7:0]  fl_dout;
    logic        fl_data_ready;
    logic        fl_busy;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        ram_wait;

    int checks = 0;
    int errors = 0;

    flash_rom_loader #(.ADDR_W(16), .LEN_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .length(length), .loading(loading), .done(done),
        .csum(csum), .fl_rst_n(fl_rst_n), .fl_addr(fl_addr), .fl_rd(fl_rd),
        .fl_terminate(fl_terminate), .fl_dout(fl_dout),
        .fl_data_ready(fl_data_ready), .fl_busy(fl_busy), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_we(ram_we), .ram_wait(ram_wait)
    );

    always #5 clk = ~clk;

    logic [7:0]  rom [0:15];
    logic [15:0] wr_addr [0:15];
    logic [7:0]  wr_data [0:15];
    int  byte_idx, rd_ctr, wr_count, cyc;
    int  rd_pulses, term_cycles, term_bursts, rstn_low, done_pulses;
    int  stall_byte, stall_left, we_stall_cycles, first_rd_cyc, busy_fall_cyc;
    bit  force_busy, stall_data_bad, prev_term;

    initial begin
        fl_busy = 1'b0; fl_data_ready = 1'b0; fl_dout = 8'h00; ram_wait = 1'b0;
        rd_ctr = 0; cyc = 0; force_busy = 1'b0; prev_term = 1'b0;
    end

    // Monitors, RAM model and reader model, all evaluated mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (fl_rd) begin
            rd_pulses++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        if (fl_terminate) begin
            term_cycles++;
            if (!prev_term) term_bursts++;
        end
        prev_term = fl_terminate;
        if (!fl_rst_n && !reset) rstn_low++;
        if (done) done_pulses++;

        if (ram_we && wr_count == stall_byte && stall_left > 0) begin
            ram_wait = 1'b1;
            stall_left--;
        end else begin
            ram_wait = 1'b0;
        end
        if (ram_we && wr_count == stall_byte) begin
            we_stall_cycles++;
            if (ram_addr !== 16'h4001 || ram_din !== 8'h22) stall_data_bad = 1'b1;
        end
        if (ram_we && !ram_wait && wr_count < 16) begin
            wr_addr[wr_count] = ram_addr;
            wr_data[wr_count] = ram_din;
            wr_count++;
        end

        if (!fl_rst_n) begin
            rd_ctr = 0; fl_busy = force_busy; fl_data_ready = 1'b0;
        end else if (force_busy) begin
            fl_busy = 1'b1; fl_data_ready = 1'b0;
        end else if (rd_ctr > 0) begin
            rd_ctr--;
            if (rd_ctr == 0) begin
                fl_busy = 1'b0; fl_data_ready = 1'b1;
                fl_dout = rom[byte_idx[3:0]];
                byte_idx++;
            end else begin
                fl_busy = 1'b1;
            end
        end else if (fl_rd) begin
            fl_busy = 1'b1; fl_data_ready = 1'b0; rd_ctr = 2;
        end else if (fl_terminate && !fl_busy) begin
            fl_busy = 1'b1;
        end else begin
            fl_busy = 1'b0; fl_data_ready = 1'b0;
        end
    end

    task automatic clear_mon();
        byte_idx = 0; wr_count = 0; rd_pulses = 0; term_cycles = 0; term_bursts = 0;
        rstn_low = 0; done_pulses = 0; stall_byte = -1; stall_left = 0;
        we_stall_cycles = 0; stall_data_bad = 1'b0; first_rd_cyc = -1; busy_fall_cyc = 0;
    endtask

    task automatic reset_dut();
        reset = 1'b1; start = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        clear_mon();
    endtask

    task automatic go(input logic [23:0] s, input logic [15:0] d, input logic [15:0] n);
        src_addr = s; dst_addr = d; length = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (done_pulses == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (done_pulses == 0) begin
            errors++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, budget);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({loading, done, fl_rd, fl_terminate, ram_we, fl_rst_n} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", {loading, done, fl_rd, fl_terminate, ram_we, fl_rst_n});
        end
        checks++;
        if ({ram_addr, ram_din, fl_addr, csum} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {ram_addr, ram_din, fl_addr, csum});
        end
        reset_dut();
        checks++;
        if (fl_rst_n !== 1'b1 || loading !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: fl_rst_n=%b loading=%b expected 1 0", fl_rst_n, loading);
        end
    endtask

    task automatic test_basic();
        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;
        clear_mon();
        go(24'h010000, 16'h4000, 16'd4);
        checks++;
        if (loading !== 1'b1 || fl_addr !== 24'h010000) begin
            errors++;
            $display("FAIL basic_latch: loading=%b fl_addr=%h expected 1 010000", loading, fl_addr);
        end
        wait_done(300, "basic");
        checks++;
        if (wr_count !== 4) begin
            errors++;
            $display("FAIL basic_wr_count: got %0d expected 4", wr_count);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_addr[i] !== 16'h4000 + 16'(i) || wr_data[i] !== rom[i]) begin
                errors++;
                $display("FAIL basic_write%0d: got %h:%h expected %h:%h", i, wr_addr[i], wr_data[i], 16'h4000 + 16'(i), rom[i]);
            end
        end
        checks++;
        if (rd_pulses !== 4 || term_bursts !== 1 || rstn_low !== 1 || done_pulses !== 1) begin
            errors++;
            $display("FAIL basic_counts: rd=%0d term=%0d rstn=%0d done=%0d expected 4 1 1 1", rd_pulses, term_bursts, rstn_low, done_pulses);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (csum !== (CSUM_ON ? 16'h00AA : 16'h0000) || loading !== 1'b0) begin
            errors++;
            $display("FAIL basic_csum: csum=%h loading=%b expected %h 0", csum, loading, CSUM_ON ? 16'h00AA : 16'h0000);
        end
    endtask

    task automatic test_zero_len();
        clear_mon();
        go(24'h020000, 16'h1000, 16'd0);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: got %b expected 1", done);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (rd_pulses !== 0 || term_cycles !== 0 || wr_count !== 0 || done_pulses !== 1 || loading !== 1'b0) begin
            errors++;
            $display("FAIL zero_quiet: rd=%0d term=%0d wr=%0d done=%0d loading=%b expected 0 0 0 1 0", rd_pulses, term_cycles, wr_count, done_pulses, loading);
        end
        checks++;
        if (csum !== 16'h0000) begin
            errors++;
            $display("FAIL zero_csum_clear: got %h expected 0000", csum);
        end
    endtask

    task automatic test_ram_wait();
        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;
        clear_mon();
        stall_byte = 1; stall_left = 5;
        go(24'h010000, 16'h4000, 16'd4);
        wait_done(300, "wait");
        checks++;
        if (we_stall_cycles !== 6 || stall_data_bad !== 1'b0) begin
            errors++;
            $display("FAIL wait_hold: we_cycles=%0d unstable=%b expected 6 0", we_stall_cycles, stall_data_bad);
        end
        checks++;
        if (wr_count !== 4 || wr_addr[1] !== 16'h4001 || wr_data[1] !== 8'h22 || wr_data[2] !== 8'h33) begin
            errors++;
            $display("FAIL wait_writes: count=%0d w1=%h:%h w2=%h expected 4 4001:22 33", wr_count, wr_addr[1], wr_data[1], wr_data[2]);
        end
        checks++;
        if (csum !== (CSUM_ON ? 16'h00AA : 16'h0000)) begin
            errors++;
            $display("FAIL wait_csum: got %h expected %h", csum, CSUM_ON ? 16'h00AA : 16'h0000);
        end
    endtask

    task automatic test_wrap();
        rom[0] = 8'hA5; rom[1] = 8'h5A;
        clear_mon();
        go(24'h030000, 16'hFFFF, 16'd2);
        wait_done(300, "wrap");
        checks++;
        if (wr_count !== 2 || wr_addr[0] !== 16'hFFFF || wr_addr[1] !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_addr: count=%0d a0=%h a1=%h expected 2 ffff 0000", wr_count, wr_addr[0], wr_addr[1]);
        end
        checks++;
        if (wr_data[0] !== 8'hA5 || wr_data[1] !== 8'h5A || csum !== (CSUM_ON ? 16'h00FF : 16'h0000)) begin
            errors++;
            $display("FAIL wrap_data: d0=%h d1=%h csum=%h expected a5 5a %h", wr_data[0], wr_data[1], csum, CSUM_ON ? 16'h00FF : 16'h0000);
        end
    endtask

    task automatic test_busy_powerup();
        rom[0] = 8'h7E;
        force_busy = 1'b1;
        reset_dut();
        go(24'h040000, 16'h0100, 16'd1);
        repeat (999) @(posedge clk);
        #1;
        checks++;
        if (first_rd_cyc !== -1 || loading !== 1'b1) begin
            errors++;
            $display("FAIL busy_hold: first_rd=%0d loading=%b expected -1 1", first_rd_cyc, loading);
        end
        force_busy = 1'b0;
        busy_fall_cyc = cyc;
        repeat (3) @(posedge clk);
        #1;
        go(24'h050000, 16'h1234, 16'd5);
        checks++;
        if (fl_addr !== 24'h040000) begin
            errors++;
            $display("FAIL busy_ignore_start: fl_addr=%h expected 040000", fl_addr);
        end
        wait_done(300, "busy");
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (!(first_rd_cyc > busy_fall_cyc + 1)) begin
            errors++;
            $display("FAIL busy_first_rd: rd at %0d release at %0d", first_rd_cyc, busy_fall_cyc);
        end
        checks++;
        if (wr_count !== 1 || wr_addr[0] !== 16'h0100 || wr_data[0] !== 8'h7E || rd_pulses !== 1 || done_pulses !== 1 || loading !== 1'b0) begin
            errors++;
            $display("FAIL busy_single: wr=%0d a=%h d=%h rd=%0d done=%0d loading=%b expected 1 0100 7e 1 1 0", wr_count, wr_addr[0], wr_data[0], rd_pulses, done_pulses, loading);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int i = 0; i < 8; i++) rom[i] = 8'h80 + 8'(i);
        clear_mon();
        go(24'h060000, 16'h2000, 16'd8);
        n = 0;
        while (!(ram_we && wr_count == 2) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!(ram_we && wr_count == 2)) begin
            errors++;
            $display("FAIL mid_reach_write3: ram_we=%b wr_count=%0d expected 1 2", ram_we, wr_count);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (loading !== 1'b0 || fl_rst_n !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: loading=%b fl_rst_n=%b ram_we=%b expected 0 0 0", loading, fl_rst_n, ram_we);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (done_pulses !== 0 || loading !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_done: done=%0d loading=%b expected 0 0", done_pulses, loading);
        end
        rom[0] = 8'h3C; rom[1] = 8'hC3;
        clear_mon();
        go(24'h070000, 16'h3000, 16'd2);
        wait_done(300, "fresh");
        checks++;
        if (wr_count !== 2 || wr_addr[0] !== 16'h3000 || wr_data[0] !== 8'h3C || wr_addr[1] !== 16'h3001 || wr_data[1] !== 8'hC3 || done_pulses !== 1) begin
            errors++;
            $display("FAIL fresh_transfer: wr=%0d %h:%h %h:%h done=%0d expected 2 3000:3c 3001:c3 1", wr_count, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], done_pulses);
        end
        checks++;
        if (csum !== (CSUM_ON ? 16'h00FF : 16'h0000)) begin
            errors++;
            $display("FAIL fresh_csum: got %h expected %h", csum, CSUM_ON ? 16'h00FF : 16'h0000);
        end
    endtask

    initial begin
        clear_mon();
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        test_reset();
        test_basic();
        test_zero_len();
        test_ram_wait();
        test_wrap();
        test_busy_powerup();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
